// File: rtl/imem_loader_if.sv
// Byte-stream handshake into the instruction memory loader.
// master drives bytes, slave (the loader) returns ready.
interface imem_loader_if;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;

    modport master (
        output rx_data,
        output rx_valid,
        input  rx_ready
    );

    modport slave (
        input  rx_data,
        input  rx_valid,
        output rx_ready
    );
endinterface

// File: rtl/imem_loader.sv
// Boot loader: assembles framed bytes into 16-bit words for imem,
// verifies an XOR checksum and holds the core until a clean load.
module imem_loader #(
    parameter int PROG_CTR_WID = 10,
    parameter int TIMEOUT_CYC  = 1000
) (
    input  logic                    clk,
    input  logic                    rst,
    imem_loader_if.slave            rx,
    input  logic                    reload,
    output logic                    imem_we,
    output logic [PROG_CTR_WID-1:0] imem_addr,
    output logic [15:0]             imem_wdata,
    output logic                    core_hold,
    output logic                    load_done,
    output logic                    load_err,
    output logic [1:0]              err_code,
    output logic [PROG_CTR_WID:0]   words_written
);

    localparam int AW = PROG_CTR_WID;
    localparam int CW = PROG_CTR_WID + 1;
    localparam int IW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [16:0] MAX_LEN = 17'(2 ** PROG_CTR_WID);
    localparam logic [IW-1:0] IDLE_LAST = IW'(TIMEOUT_CYC - 1);

    typedef enum logic [2:0] {
        S_LEN_LO,
        S_LEN_HI,
        S_INS_LO,
        S_INS_HI,
        S_CSUM,
        S_DONE,
        S_ERR
    } state_t;

    state_t          state_q, state_d;
    logic [15:0]     len_q, len_d;
    logic [7:0]      lo_q, lo_d;
    logic [7:0]      xor_q, xor_d;
    logic [IW-1:0]   idle_q, idle_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [15:0]     wdata_q, wdata_d;
    logic            we_q, we_d;
    logic            hold_q, hold_d;
    logic            done_q, done_d;
    logic            err_q, err_d;
    logic [1:0]      code_q, code_d;
    logic            ready_q, ready_d;

    logic            acc;
    logic            timing;
    logic            tmo;
    logic [15:0]     len_new;

    assign acc     = rx.rx_valid && ready_q;
    assign len_new = {rx.rx_data, len_q[7:0]};
    assign timing  = (state_q == S_LEN_HI) || (state_q == S_INS_LO)
                  || (state_q == S_INS_HI) || (state_q == S_CSUM);
    assign tmo     = timing && !acc && (idle_q == IDLE_LAST);

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        lo_d    = lo_q;
        xor_d   = xor_q;
        idle_d  = '0;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        we_d    = 1'b0;
        hold_d  = hold_q;
        done_d  = done_q;
        err_d   = err_q;
        code_d  = code_q;

        if (timing && !acc) begin
            idle_d = idle_q + IW'(1);
        end

        unique case (state_q)
            S_LEN_LO: begin
                if (acc) begin
                    len_d[7:0] = rx.rx_data;
                    state_d    = S_LEN_HI;
                end
            end
            S_LEN_HI: begin
                if (acc) begin
                    len_d = len_new;
                    if ({1'b0, len_new} > MAX_LEN) begin
                        state_d = S_ERR;
                        err_d   = 1'b1;
                        code_d  = 2'd1;
                    end else if (len_new == 16'd0) begin
                        state_d = S_CSUM;
                    end else begin
                        state_d = S_INS_LO;
                    end
                end
            end
            S_INS_LO: begin
                if (acc) begin
                    lo_d    = rx.rx_data;
                    xor_d   = xor_q ^ rx.rx_data;
                    state_d = S_INS_HI;
                end
            end
            S_INS_HI: begin
                if (acc) begin
                    xor_d   = xor_q ^ rx.rx_data;
                    we_d    = 1'b1;
                    wdata_d = {rx.rx_data, lo_q};
                    addr_d  = cnt_q[AW-1:0];
                    cnt_d   = cnt_q + CW'(1);
                    if (17'(cnt_q) + 17'd1 == {1'b0, len_q}) begin
                        state_d = S_CSUM;
                    end else begin
                        state_d = S_INS_LO;
                    end
                end
            end
            S_CSUM: begin
                if (acc) begin
                    if (rx.rx_data == xor_q) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = S_ERR;
                        err_d   = 1'b1;
                        code_d  = 2'd2;
                    end
                end
            end
            S_DONE: begin
                // release only once no write is still in flight
                if (!we_q) begin
                    hold_d = 1'b0;
                end
            end
            S_ERR: begin
                hold_d = 1'b1;
            end
            default: begin
                state_d = S_LEN_LO;
            end
        endcase

        if (tmo) begin
            state_d = S_ERR;
            err_d   = 1'b1;
            code_d  = 2'd3;
        end

        if ((state_q == S_DONE || state_q == S_ERR) && reload) begin
            state_d = S_LEN_LO;
            err_d   = 1'b0;
            code_d  = 2'd0;
            done_d  = 1'b0;
            cnt_d   = '0;
            addr_d  = '0;
            xor_d   = '0;
            hold_d  = 1'b1;
        end

        ready_d = (state_d != S_DONE) && (state_d != S_ERR);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_LEN_LO;
            len_q   <= '0;
            lo_q    <= '0;
            xor_q   <= '0;
            idle_q  <= '0;
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
            hold_q  <= 1'b1;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            code_q  <= 2'd0;
            ready_q <= 1'b1;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            lo_q    <= lo_d;
            xor_q   <= xor_d;
            idle_q  <= idle_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            we_q    <= we_d;
            hold_q  <= hold_d;
            done_q  <= done_d;
            err_q   <= err_d;
            code_q  <= code_d;
            ready_q <= ready_d;
        end
    end

    assign rx.rx_ready    = ready_q;
    assign imem_we        = we_q;
    assign imem_addr      = addr_q;
    assign imem_wdata     = wdata_q;
    assign core_hold      = hold_q;
    assign load_done      = done_q;
    assign load_err       = err_q;
    assign err_code       = code_q;
    assign words_written  = cnt_q;

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: directed frame table, timeout and reset
// corners, then random frames against a frame-level model.
module tb_imem_loader;

    localparam int W = 10;
    localparam int T = 1000;
    localparam int MAXN = 2 ** W;

    logic          clk;
    logic          rst;
    logic          reload;
    logic          imem_we;
    logic [W-1:0]  imem_addr;
    logic [15:0]   imem_wdata;
    logic          core_hold;
    logic          load_done;
    logic          load_err;
    logic [1:0]    err_code;
    logic [W:0]    words_written;

    imem_loader_if bus ();

    imem_loader #(
        .PROG_CTR_WID (W),
        .TIMEOUT_CYC  (T)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .rx            (bus),
        .reload        (reload),
        .imem_we       (imem_we),
        .imem_addr     (imem_addr),
        .imem_wdata    (imem_wdata),
        .core_hold     (core_hold),
        .load_done     (load_done),
        .load_err      (load_err),
        .err_code      (err_code),
        .words_written (words_written)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_pass = 0;

    int wr_a[$];
    int wr_d[$];

    always @(negedge clk) begin
        if (imem_we) begin
            wr_a.push_back(int'(imem_addr));
            wr_d.push_back(int'(imem_wdata));
        end
    end

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        bus.rx_valid = 1'b0;
        repeat (gap) @(negedge clk);
        bus.rx_data  = b;
        bus.rx_valid = 1'b1;
        @(negedge clk);
        bus.rx_valid = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        bus.rx_valid = 1'b0;
        reload = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        wr_a.delete();
        wr_d.delete();
    endtask

    task automatic do_reload();
        reload = 1'b1;
        @(negedge clk);
        reload = 1'b0;
        wr_a.delete();
        wr_d.delete();
    endtask

    task automatic chk_rst(input string tag);
        chk({tag, ".rx_ready"}, int'(bus.rx_ready), 1);
        chk({tag, ".core_hold"}, int'(core_hold), 1);
        chk({tag, ".imem_we"}, int'(imem_we), 0);
        chk({tag, ".imem_addr"}, int'(imem_addr), 0);
        chk({tag, ".imem_wdata"}, int'(imem_wdata), 0);
        chk({tag, ".load_done"}, int'(load_done), 0);
        chk({tag, ".load_err"}, int'(load_err), 0);
        chk({tag, ".err_code"}, int'(err_code), 0);
        chk({tag, ".words"}, int'(words_written), 0);
    endtask

    typedef struct {
        logic [63:0] bytes;
        int          nb;
        int          done;
        int          err;
        int          code;
        int          words;
        int          nw;
        int          w0;
        int          w1;
    } vec_t;

    vec_t tbl[6];

    logic [7:0] fr[$];
    int         exp_d[$];
    int         n;
    int         good;
    int         exp_done;
    int         exp_err;
    int         exp_code;
    int         exp_words;
    int         bad;
    logic [7:0] x;
    logic [7:0] b;

    initial begin
        rst = 1'b1;
        reload = 1'b0;
        bus.rx_valid = 1'b0;
        bus.rx_data = 8'h00;

        tbl[0] = '{64'h00_1B_10_02_08_01_00_02, 7, 1, 0, 0, 2, 2,
                   32'h0000_0801, 32'h0001_1002};
        tbl[1] = '{64'h00_1A_10_02_08_01_00_02, 7, 0, 1, 2, 2, 2,
                   32'h0000_0801, 32'h0001_1002};
        tbl[2] = '{64'h0401, 2, 0, 1, 1, 0, 0, 0, 0};
        tbl[3] = '{64'h00_00_00, 3, 1, 0, 0, 0, 0, 0, 0};
        tbl[4] = '{64'h05_00_00, 3, 0, 1, 2, 0, 0, 0, 0};
        tbl[5] = '{64'h26_12_34_00_01, 5, 1, 0, 0, 1, 1,
                   32'h0000_1234, 0};

        do_reset();
        chk_rst("reset");

        for (int v = 0; v < 6; v++) begin
            do_reset();
            for (int k = 0; k < tbl[v].nb; k++)
                send_byte(tbl[v].bytes[8*k +: 8], 0);
            chk($sformatf("v%0d.done_now", v), int'(load_done), tbl[v].done);
            chk($sformatf("v%0d.err_now", v), int'(load_err), tbl[v].err);
            chk($sformatf("v%0d.hold_now", v), int'(core_hold), 1);
            @(negedge clk);
            chk($sformatf("v%0d.hold", v), int'(core_hold), 1 - tbl[v].done);
            repeat (2) @(negedge clk);
            chk($sformatf("v%0d.code", v), int'(err_code), tbl[v].code);
            chk($sformatf("v%0d.words", v), int'(words_written), tbl[v].words);
            chk($sformatf("v%0d.ready", v), int'(bus.rx_ready), 0);
            chk($sformatf("v%0d.nwr", v), wr_a.size(), tbl[v].nw);
            if (tbl[v].nw >= 1)
                chk($sformatf("v%0d.w0", v), (wr_a[0] << 16) | wr_d[0], tbl[v].w0);
            if (tbl[v].nw >= 2)
                chk($sformatf("v%0d.w1", v), (wr_a[1] << 16) | wr_d[1], tbl[v].w1);
        end

        // stall of exactly T idle cycles after LEN_LO times out
        do_reset();
        send_byte(8'h05, 0);
        repeat (T) @(negedge clk);
        chk("tmo.err", int'(load_err), 1);
        chk("tmo.code", int'(err_code), 3);
        chk("tmo.hold", int'(core_hold), 1);
        chk("tmo.ready", int'(bus.rx_ready), 0);
        do_reload();
        chk("reload.code", int'(err_code), 0);
        chk("reload.ready", int'(bus.rx_ready), 1);
        send_byte(8'h01, 0);
        send_byte(8'h00, 0);
        send_byte(8'h34, 0);
        send_byte(8'h12, 0);
        send_byte(8'h26, 0);
        repeat (3) @(negedge clk);
        chk("reload.done", int'(load_done), 1);
        chk("reload.code2", int'(err_code), 0);
        chk("reload.hold", int'(core_hold), 0);
        chk("reload.wr", (wr_a.size() << 16) | wr_d[0], 32'h0001_1234);

        // byte arriving on the last allowed idle cycle wins
        do_reset();
        send_byte(8'h00, 0);
        send_byte(8'h00, T - 1);
        chk("edge.no_err", int'(load_err), 0);
        send_byte(8'h00, 0);
        @(negedge clk);
        chk("edge.done", int'(load_done), 1);

        // reset while in INS_HI with a byte offered
        do_reset();
        send_byte(8'h01, 0);
        send_byte(8'h00, 0);
        send_byte(8'h34, 0);
        bus.rx_data = 8'h12;
        bus.rx_valid = 1'b1;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        bus.rx_valid = 1'b0;
        chk_rst("rst_inshi");

        // reset during the write pulse: the write still lands
        do_reset();
        send_byte(8'h01, 0);
        send_byte(8'h00, 0);
        send_byte(8'h34, 0);
        send_byte(8'h12, 0);
        chk("rst_we.we", int'(imem_we), 1);
        chk("rst_we.data", int'(imem_wdata), 32'h1234);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk_rst("rst_we");

        // random frames against the model
        do_reset();
        for (int f = 0; f < 14; f++) begin
            if (f == 5) n = MAXN;
            else if (f == 9) n = MAXN + 1 + int'($urandom_range(0, 300));
            else n = int'($urandom_range(0, 24));
            good = ($urandom_range(0, 3) != 0) ? 1 : 0;
            fr.delete();
            exp_d.delete();
            fr.push_back(n[7:0]);
            fr.push_back(n[15:8]);
            if (n > MAXN) begin
                exp_done = 0;
                exp_err = 1;
                exp_code = 1;
                exp_words = 0;
            end else begin
                x = 8'h00;
                for (int i = 0; i < 2 * n; i++) begin
                    b = 8'($urandom);
                    fr.push_back(b);
                    x = x ^ b;
                end
                for (int i = 0; i < n; i++)
                    exp_d.push_back(int'({fr[3 + 2*i], fr[2 + 2*i]}));
                if (good == 0) x = x ^ 8'($urandom_range(1, 255));
                fr.push_back(x);
                exp_done = good;
                exp_err = 1 - good;
                exp_code = good ? 0 : 2;
                exp_words = n;
            end

            foreach (fr[k])
                send_byte(fr[k], ($urandom_range(0, 9) == 0) ?
                          int'($urandom_range(5, 50)) :
                          int'($urandom_range(0, 2)));
            repeat (3) @(negedge clk);

            chk($sformatf("r%0d.done", f), int'(load_done), exp_done);
            chk($sformatf("r%0d.err", f), int'(load_err), exp_err);
            chk($sformatf("r%0d.code", f), int'(err_code), exp_code);
            chk($sformatf("r%0d.words", f), int'(words_written), exp_words);
            chk($sformatf("r%0d.hold", f), int'(core_hold), 1 - exp_done);
            chk($sformatf("r%0d.nwr", f), wr_a.size(), exp_d.size());
            bad = 0;
            foreach (wr_a[i]) begin
                if (i >= exp_d.size()) bad++;
                else if (wr_a[i] != i || wr_d[i] != exp_d[i]) bad++;
            end
            chk($sformatf("r%0d.wr_errs", f), bad, 0);

            do_reload();
            chk($sformatf("r%0d.clr_words", f), int'(words_written), 0);
            chk($sformatf("r%0d.clr_flags", f),
                int'({load_done, load_err, err_code}), 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
